// File: rtl/mlp_seq_classifier_if.sv
// Valid/ready bundle for mlp_seq_classifier: feature vector in, class index and neuron values out.
interface mlp_seq_classifier_if #(
    parameter int N_IN   = 21,
    parameter int IN_W   = 4,
    parameter int N_OUT  = 3,
    parameter int OACC_W = 21
);
    localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [N_IN*IN_W-1:0]          inp;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_W-1:0]              out;
    logic [N_OUT*(OACC_W-1)-1:0]   predo;

    modport master (
        output in_valid, inp, out_ready,
        input  in_ready, out_valid, out, predo
    );

    modport slave (
        input  in_valid, inp, out_ready,
        output in_ready, out_valid, out, predo
    );
endinterface

// File: rtl/mlp_seq_classifier.sv
// Time-multiplexed 2-layer ReLU MLP with argmax, one shared MAC, coefficients as parameters.
// Define MLP_ACC_SAT_EN to make accumulator adds saturate instead of wrap.
module mlp_seq_classifier #(
    parameter int N_IN   = 21,
    parameter int IN_W   = 4,
    parameter int N_HID  = 3,
    parameter int N_OUT  = 3,
    parameter int W_W    = 8,
    parameter int HACC_W = 14,
    parameter int OACC_W = 21,
    parameter logic [N_HID*N_IN*W_W-1:0]  W0 = '0,
    parameter logic [N_HID*HACC_W-1:0]    B0 = '0,
    parameter logic [N_OUT*N_HID*W_W-1:0] W1 = '0,
    parameter logic [N_OUT*OACC_W-1:0]    B1 = '0
) (
    input  logic                clk,
    input  logic                rst,
    mlp_seq_classifier_if.slave bus
);
    localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int PW    = HACC_W + W_W;
    localparam int MW    = (PW > OACC_W) ? PW : OACC_W;
    localparam int SW    = ((MW > HACC_W) ? MW : HACC_W) + 1;
    localparam int CNT_W = $clog2(N_IN + N_HID + N_OUT + 1);
    localparam int HV_W  = HACC_W - 1;
    localparam int OV_W  = OACC_W - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] L0   = 2'd1;
    localparam logic [1:0] L1   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      row_reg;
    logic [CNT_W-1:0]      col_reg;
    logic [N_IN*IN_W-1:0]  feat_reg;
    logic [N_HID*HV_W-1:0] hid_reg;
    logic [N_OUT*OV_W-1:0] pred_reg;
    logic signed [SW-1:0]  acc_reg;
    logic [OV_W-1:0]       best_val_reg;
    logic [OV_W-1:0]       cand_val_reg;
    logic [OUT_W-1:0]      best_idx_reg;
    logic [OUT_W-1:0]      cand_idx_reg;
    logic [OUT_W-1:0]      out_reg;

    // Bring a full-precision sum back into a w-bit accumulator, sign-extended to SW.
    function automatic logic signed [SW-1:0] fit(input logic signed [SW-1:0] s, input int w);
`ifdef MLP_ACC_SAT_EN
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = (SW'(1) <<< (w - 1)) - SW'(1);
        lo = -hi - SW'(1);
        if (s > hi)
            fit = hi;
        else if (s < lo)
            fit = lo;
        else
            fit = s;
`else
        fit = (s <<< (SW - w)) >>> (SW - w);
`endif
    endfunction

    logic                 in_l0;
    logic                 first;
    logic                 last_col;
    logic                 take;
    logic [HACC_W-1:0]    a_op;
    logic signed [W_W-1:0] w_sel;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] bias;
    logic signed [SW-1:0] base;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] fitted;
    logic [HV_W-1:0]      relu_h;
    logic [OV_W-1:0]      relu_o;
    logic [OUT_W-1:0]     win_idx;
    logic [OV_W-1:0]      win_val;

    always_comb begin
        in_l0 = (state_reg == L0);
        first = (col_reg == '0);
        if (in_l0) begin
            a_op     = HACC_W'(feat_reg[col_reg*IN_W +: IN_W]);
            w_sel    = W0[(row_reg*N_IN + col_reg)*W_W +: W_W];
            bias     = SW'($signed(B0[row_reg*HACC_W +: HACC_W]));
            last_col = (col_reg == CNT_W'(N_IN - 1));
        end else begin
            a_op     = {1'b0, hid_reg[col_reg*HV_W +: HV_W]};
            w_sel    = W1[(row_reg*N_HID + col_reg)*W_W +: W_W];
            bias     = SW'($signed(B1[row_reg*OACC_W +: OACC_W]));
            last_col = (col_reg == CNT_W'(N_HID - 1));
        end
        prod   = PW'($signed(a_op)) * PW'(w_sel);
        base   = first ? bias : acc_reg;
        sum    = base + SW'(prod);
        fitted = fit(sum, in_l0 ? HACC_W : OACC_W);
        relu_h = fitted[SW-1] ? '0 : fitted[HV_W-1:0];
        relu_o = fitted[SW-1] ? '0 : fitted[OV_W-1:0];
        // Strictly greater keeps the lower index on ties.
        take    = (cand_val_reg > best_val_reg);
        win_idx = take ? cand_idx_reg : best_idx_reg;
        win_val = take ? cand_val_reg : best_val_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            feat_reg     <= '0;
            hid_reg      <= '0;
            pred_reg     <= '0;
            acc_reg      <= '0;
            best_val_reg <= '0;
            cand_val_reg <= '0;
            best_idx_reg <= '0;
            cand_idx_reg <= '0;
            out_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        feat_reg  <= bus.inp;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        state_reg <= L0;
                    end
                end
                L0: begin
                    acc_reg <= fitted;
                    if (last_col) begin
                        hid_reg[row_reg*HV_W +: HV_W] <= relu_h;
                        col_reg <= '0;
                        if (row_reg == CNT_W'(N_HID - 1)) begin
                            row_reg      <= '0;
                            state_reg    <= L1;
                            best_val_reg <= '0;
                            best_idx_reg <= '0;
                            cand_val_reg <= '0;
                            cand_idx_reg <= '0;
                        end else begin
                            row_reg <= row_reg + CNT_W'(1);
                        end
                    end else begin
                        col_reg <= col_reg + CNT_W'(1);
                    end
                end
                L1: begin
                    // The compare trails neuron completion by one cycle; row == N_OUT is the drain step.
                    best_val_reg <= win_val;
                    best_idx_reg <= win_idx;
                    if (row_reg == CNT_W'(N_OUT)) begin
                        out_reg   <= win_idx;
                        state_reg <= DONE;
                    end else begin
                        acc_reg <= fitted;
                        if (last_col) begin
                            pred_reg[(N_OUT - 1 - row_reg)*OV_W +: OV_W] <= relu_o;
                            cand_val_reg <= relu_o;
                            cand_idx_reg <= OUT_W'(row_reg);
                            col_reg      <= '0;
                            row_reg      <= row_reg + CNT_W'(1);
                        end else begin
                            col_reg <= col_reg + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out       = out_reg;
    assign bus.predo     = pred_reg;
endmodule

// File: tb/tb_mlp_seq_classifier.sv
// Directed bench for mlp_seq_classifier: cardio coefficients, all-zero and overflow instances.
module tb_mlp_seq_classifier;
    localparam int N_IN = 21, IN_W = 4, N_HID = 3, N_OUT = 3, W_W = 8, HACC_W = 14, OACC_W = 21;
    localparam int XW = N_IN*IN_W;
    localparam int OV_W = OACC_W - 1;
    localparam int PDW = N_OUT*OV_W;

    function automatic logic [N_HID*N_IN*W_W-1:0] mk_w0();
        logic [N_HID*N_IN*W_W-1:0] r;
        r = '0;
        for (int h = 0; h < N_HID; h++) begin
            for (int i = 0; i < N_IN; i++) begin
                int w;
                if (h == 0) w = -8;
                else if (h == 1) w = (i < 10) ? 4 : 0;
                else w = (i >= 10) ? 6 : 0;
                r[(h*N_IN + i)*W_W +: W_W] = W_W'(w);
            end
        end
        return r;
    endfunction

    localparam logic [N_HID*N_IN*W_W-1:0]  W0_A = mk_w0();
    localparam logic [N_HID*HACC_W-1:0]    B0_A = {14'd545, 14'd164, 14'd408};
    localparam logic [N_OUT*N_HID*W_W-1:0] W1_A = {8'sd72, 8'sd52, -8'sd126, -8'sd48, 8'sd40, -8'sd44, -8'sd56, -8'sd80, 8'sd72};
    localparam logic [N_OUT*OACC_W-1:0]    B1_A = {-21'sd40698, -21'sd20843, 21'sd33717};
    localparam logic [N_HID*N_IN*W_W-1:0]  W0_S = {63{8'd127}};
    localparam logic [N_OUT*N_HID*W_W-1:0] W1_S = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
`ifdef MLP_ACC_SAT_EN
    localparam logic [OV_W-1:0] HID_S = 20'd8191;
`else
    localparam logic [OV_W-1:0] HID_S = 20'd7237;
`endif
    localparam logic [PDW-1:0] T1_PREDO = {20'd19453, 20'd0, 20'd0};

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mlp_seq_classifier_if #(.N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OACC_W(OACC_W)) if_a ();
    mlp_seq_classifier_if #(.N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OACC_W(OACC_W)) if_z ();
    mlp_seq_classifier_if #(.N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OACC_W(OACC_W)) if_s ();

    mlp_seq_classifier #(.W0(W0_A), .B0(B0_A), .W1(W1_A), .B1(B1_A))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    mlp_seq_classifier u_z (.clk(clk), .rst(rst), .bus(if_z));
    mlp_seq_classifier #(.W0(W0_S), .W1(W1_S))
        u_s (.clk(clk), .rst(rst), .bus(if_s));

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Straightforward integer evaluation of the network; returns {class, predo}.
    function automatic logic [PDW+1:0] model(input logic [XW-1:0] x);
        int hid [N_HID];
        int acc, v, bestv;
        logic [1:0] cls;
        logic [PDW-1:0] pd;
        pd = '0; cls = '0; bestv = -1;
        for (int h = 0; h < N_HID; h++) begin
            acc = int'($signed(B0_A[h*HACC_W +: HACC_W]));
            for (int i = 0; i < N_IN; i++)
                acc += int'(x[i*IN_W +: IN_W]) * int'($signed(W0_A[(h*N_IN + i)*W_W +: W_W]));
            hid[h] = (acc < 0) ? 0 : acc;
        end
        for (int o = 0; o < N_OUT; o++) begin
            acc = int'($signed(B1_A[o*OACC_W +: OACC_W]));
            for (int h = 0; h < N_HID; h++)
                acc += hid[h] * int'($signed(W1_A[(o*N_HID + h)*W_W +: W_W]));
            v = (acc < 0) ? 0 : acc;
            pd[(N_OUT - 1 - o)*OV_W +: OV_W] = OV_W'(v);
            if (v > bestv) begin
                bestv = v;
                cls = 2'(o);
            end
        end
        return {cls, pd};
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen (bounded).
    task automatic run_a(input logic [XW-1:0] x, output int lat);
        if_a.inp = x;
        if_a.in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        if_a.in_valid = 1'b0;
        while (!if_a.out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("txn inp=%h latency=%0d out=%0d predo=%h", x, lat, if_a.out, if_a.predo);
    endtask

    logic [XW-1:0]  vecs [3];
    logic [PDW-1:0] hand_predo [3];
    logic [1:0]     hand_out [3];
    logic [PDW+1:0] ref_res;
    int lat;
    logic seen;

    initial begin
        rst = 1'b1;
        if_a.in_valid = 0; if_a.inp = '0; if_a.out_ready = 0;
        if_z.in_valid = 0; if_z.inp = '0; if_z.out_ready = 0;
        if_s.in_valid = 0; if_s.inp = '0; if_s.out_ready = 0;
        vecs[0] = {21{4'hf}};               hand_predo[0] = {20'd0, 20'd0, 20'd109550}; hand_out[0] = 2'd2;
        vecs[1] = {{11{4'h0}}, {10{4'hf}}}; hand_predo[1] = {20'd0, 20'd0, 20'd38270};  hand_out[1] = 2'd2;
        vecs[2] = {{11{4'h0}}, {10{4'h1}}}; hand_predo[2] = {20'd10493, 20'd0, 20'd0};  hand_out[2] = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(if_a.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_out", 64'(if_a.out), 64'd0);
        chk("rst_predo", 64'(if_a.predo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cardio coefficients with zero input
        run_a('0, lat);
        chk("t1_latency", 64'(lat), 64'd73);
        chk("t1_predo", 64'(if_a.predo), 64'(T1_PREDO));
        chk("t1_out", 64'(if_a.out), 64'd0);
        chk("t1_in_ready", 64'(if_a.in_ready), 64'd0);

        // Back-pressure: result held while in_valid/inp toggle
        for (int k = 0; k < 10; k++) begin
            if_a.in_valid = k[0];
            if_a.inp = XW'({$urandom, $urandom, $urandom});
            @(negedge clk);
            chk("t3_hold_valid", 64'(if_a.out_valid), 64'd1);
            chk("t3_hold_predo", 64'(if_a.predo), 64'(T1_PREDO));
            chk("t3_hold_out", 64'(if_a.out), 64'd0);
            chk("t3_hold_in_ready", 64'(if_a.in_ready), 64'd0);
        end
        if_a.in_valid = 0;
        if_a.out_ready = 1;
        @(negedge clk);
        if_a.out_ready = 0;
        chk("t3_release_valid", 64'(if_a.out_valid), 64'd0);
        chk("t3_release_in_ready", 64'(if_a.in_ready), 64'd1);
        chk("t3_idle_predo", 64'(if_a.predo), 64'(T1_PREDO));
        @(negedge clk);
        chk("t3_no_accept", 64'(if_a.in_ready), 64'd1);

        // Reset in the middle of L0
        if_a.inp = {21{4'h3}};
        if_a.in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        if_a.in_valid = 0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_out_valid", 64'(if_a.out_valid), 64'd0);
        chk("t4_in_ready", 64'(if_a.in_ready), 64'd1);
        chk("t4_predo", 64'(if_a.predo), 64'd0);
        chk("t4_out", 64'(if_a.out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (if_a.out_valid) seen = 1;
        end
        chk("t4_no_partial", 64'(seen), 64'd0);
        run_a('0, lat);
        chk("t4_latency", 64'(lat), 64'd73);
        chk("t4_predo", 64'(if_a.predo), 64'(T1_PREDO));
        chk("t4_out", 64'(if_a.out), 64'd0);
        if_a.out_ready = 1;
        @(negedge clk);
        if_a.out_ready = 0;
        chk("t4_in_ready_after", 64'(if_a.in_ready), 64'd1);

        // Back-to-back transactions
        for (int k = 0; k < 3; k++) begin
            ref_res = model(vecs[k]);
            run_a(vecs[k], lat);
            chk("t6_latency", 64'(lat), 64'd73);
            chk("t6_predo_hand", 64'(if_a.predo), 64'(hand_predo[k]));
            chk("t6_out_hand", 64'(if_a.out), 64'(hand_out[k]));
            chk("t6_predo_model", 64'(if_a.predo), 64'(ref_res[PDW-1:0]));
            chk("t6_out_model", 64'(if_a.out), 64'(ref_res[PDW+1:PDW]));
            if_a.out_ready = 1;
            @(negedge clk);
            if_a.out_ready = 0;
            chk("t6_in_ready_rise", 64'(if_a.in_ready), 64'd1);
            chk("t6_out_valid_drop", 64'(if_a.out_valid), 64'd0);
        end

        // All-zero coefficients and hidden-layer overflow
        if_z.inp = {21{4'ha}};
        if_s.inp = {21{4'hf}};
        if_z.in_valid = 1;
        if_s.in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        if_z.in_valid = 0;
        if_s.in_valid = 0;
        repeat (80) @(negedge clk);
        $display("txn zero out=%0d predo=%h", if_z.out, if_z.predo);
        $display("txn ovf out=%0d predo=%h", if_s.out, if_s.predo);
        chk("t2_out_valid", 64'(if_z.out_valid), 64'd1);
        chk("t2_predo", 64'(if_z.predo), 64'd0);
        chk("t2_out", 64'(if_z.out), 64'd0);
        chk("t5_out_valid", 64'(if_s.out_valid), 64'd1);
        chk("t5_predo", 64'(if_s.predo), 64'({HID_S, HID_S, HID_S}));
        chk("t5_out", 64'(if_s.out), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
